// File: rtl/prng_lfsr_ctrl.sv
// prng_lfsr_ctrl: push-button driven Fibonacci-style LFSR number generator.
// The button is synchronised and debounced into a one-cycle press event.
// A three-state FSM (STEP / RUN / PAUSE) decides when the LFSR advances.
// i_seed_load overrides any advance, and a zero seed is replaced by SEED
// so that the LFSR can never lock up in the all-zero state.
//
// Output event semantics: o_valid is a single-cycle pulse. It is high in the
// first cycle that a new o_number (from a load or an advance) is visible.
// There is no back-pressure: a consumer that misses the pulse misses the value.
module prng_lfsr_ctrl #(
    parameter int                 WIDTH    = 8,
    parameter logic [WIDTH-1:0]   TAPS     = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0]   SEED     = WIDTH'(1),
    parameter int                 DEBOUNCE = 4,
    parameter int                 PRESCALE = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             button,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_seed_load,
    output logic [WIDTH-1:0] o_number,
    output logic             o_valid,
    output logic             o_lockup,
    output logic             o_running,
    output logic [1:0]       o_dbg_state
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE - 1);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_STEP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    logic [2:0]       r_sync;
    logic             r_db_level;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_press;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_advance;
    logic [PS_W-1:0]  r_ps;
    logic [WIDTH-1:0] r_lfsr;
    logic             r_valid;
    logic             r_lockup;

    logic             w_sync_bit;
    logic             w_db_diff;
    logic             w_db_done;
    logic             w_fb;
    logic [WIDTH-1:0] w_lfsr_next;
    logic [WIDTH-1:0] w_lfsr_safe;
    logic             w_seed_zero;

    assign w_sync_bit = r_sync[2];
    assign w_db_diff  = (w_sync_bit != r_db_level);
    assign w_db_done  = w_db_diff && (r_db_cnt == DB_MAX);

    // Three-flop synchroniser for the asynchronous button; idles high (released).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= 3'b111;
        end else begin
            r_sync <= {r_sync[1:0], button};
        end
    end

    // Debouncer: accept a level change only after DEBOUNCE consecutive
    // disagreeing cycles; register a press pulse on an accepted 1->0 change.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_db_level <= 1'b1;
            r_db_cnt   <= '0;
            r_press    <= 1'b0;
        end else begin
            r_press <= w_db_done && r_db_level;
            if (w_db_done) begin
                r_db_level <= w_sync_bit;
                r_db_cnt   <= '0;
            end else if (w_db_diff) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_STEP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and advance request; a press that changes state never advances.
    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        case (r_state)
            ST_STEP: begin
                if (i_mode) begin
                    w_state_nxt = ST_RUN;
                end else if (r_press) begin
                    w_advance = 1'b1;
                end
            end
            ST_RUN: begin
                if (!i_mode) begin
                    w_state_nxt = ST_STEP;
                end else if (r_press) begin
                    w_state_nxt = ST_PAUSE;
                end else if (r_ps == PS_MAX) begin
                    w_advance = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (!i_mode) begin
                    w_state_nxt = ST_STEP;
                end else if (r_press) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_STEP;
            end
        endcase
    end

    // Prescaler: counts only while staying in RUN, so every RUN entry starts at 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ps <= '0;
        end else if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
            r_ps <= (r_ps == PS_MAX) ? '0 : r_ps + 1'b1;
        end else begin
            r_ps <= '0;
        end
    end

    assign w_fb        = ^(r_lfsr & TAPS);
    assign w_lfsr_next = {r_lfsr[WIDTH-2:0], w_fb};
    // Guards against a degenerate TAPS mask shifting the state into zero.
    assign w_lfsr_safe = (w_lfsr_next == '0) ? SEED : w_lfsr_next;
    assign w_seed_zero = (i_seed == '0);

    // LFSR state with seed load taking priority over (and dropping) an advance.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lfsr   <= SEED;
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
        end else if (i_seed_load) begin
            r_lfsr   <= w_seed_zero ? SEED : i_seed;
            r_valid  <= 1'b1;
            r_lockup <= w_seed_zero;
        end else if (w_advance) begin
            r_lfsr   <= w_lfsr_safe;
            r_valid  <= 1'b1;
            r_lockup <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
        end
    end

    assign o_number    = r_lfsr;
    assign o_valid     = r_valid;
    assign o_lockup    = r_lockup;
    assign o_running   = (r_state == ST_RUN);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prng_lfsr_ctrl.sv
// Directed bench for prng_lfsr_ctrl with default parameters
// (WIDTH=8, TAPS=8'hB8, SEED=1, DEBOUNCE=4, PRESCALE=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_prng_lfsr_ctrl;

    logic       clk;
    logic       rst_n;
    logic       button;
    logic       i_mode;
    logic [7:0] i_seed;
    logic       i_seed_load;
    logic [7:0] o_number;
    logic       o_valid;
    logic       o_lockup;
    logic       o_running;
    logic [1:0] o_dbg_state;

    int n_cmp;
    int n_err;

    logic [7:0] exp_num;
    int         cnt;

    prng_lfsr_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .button      (button),
        .i_mode      (i_mode),
        .i_seed      (i_seed),
        .i_seed_load (i_seed_load),
        .o_number    (o_number),
        .o_valid     (o_valid),
        .o_lockup    (o_lockup),
        .o_running   (o_running),
        .o_dbg_state (o_dbg_state)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference next-state for x^8 taps at bits 7,5,4,3.
    function automatic logic [7:0] nxt(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles and count o_valid pulses seen.
    task automatic tick_count(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_valid) pulses++;
        end
    endtask

    // One clean press in STEP mode with latency checks (edge 0 = first low sample).
    task automatic step_press(input string tag, input logic [7:0] prev, input logic [7:0] exp);
        int p;
        button = 1'b0;
        repeat (7) tick();
        check({tag, "_pre_valid"}, o_valid, 0);
        check({tag, "_pre_num"}, o_number, prev);
        tick();
        check({tag, "_valid"}, o_valid, 1);
        check({tag, "_num"}, o_number, exp);
        tick();
        check({tag, "_valid_drop"}, o_valid, 0);
        repeat (6) tick();
        button = 1'b1;
        tick_count(14, p);
        check({tag, "_release_pulses"}, p, 0);
        check({tag, "_hold_num"}, o_number, exp);
    endtask

    initial begin
        bit seen [256];
        int distinct;
        int waited;
        logic [7:0] prev;

        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        button      = 1'b1;
        i_mode      = 1'b0;
        i_seed      = 8'h00;
        i_seed_load = 1'b0;

        // Reset state.
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_num", o_number, 8'h01);
        check("rst_valid", o_valid, 0);
        check("rst_running", o_running, 0);
        check("rst_lockup", o_lockup, 0);
        check("rst_state", o_dbg_state, 0);

        // Four single-step presses.
        step_press("p1", 8'h01, 8'h02);
        step_press("p2", 8'h02, 8'h04);
        step_press("p3", 8'h04, 8'h08);
        step_press("p4", 8'h08, 8'h11);
        exp_num = 8'h11;

        // Glitch shorter than the debounce window.
        button = 1'b0;
        repeat (3) tick();
        button = 1'b1;
        tick_count(20, cnt);
        check("glitch_pulses", cnt, 0);
        check("glitch_num", o_number, exp_num);

        // Long hold produces exactly one advance.
        button = 1'b0;
        tick_count(100, cnt);
        button = 1'b1;
        begin
            int c2;
            tick_count(15, c2);
            cnt += c2;
        end
        check("hold_pulses", cnt, 1);
        exp_num = 8'h23;
        check("hold_num", o_number, exp_num);

        // Free-run: first advance 4 cycles after RUN entry, then every 4.
        i_mode = 1'b1;
        tick();
        check("run_entry_running", o_running, 1);
        check("run_entry_state", o_dbg_state, 1);
        for (int p = 0; p < 4; p++) begin
            repeat (3) begin
                tick();
                check("run_gap_valid", o_valid, 0);
            end
            tick();
            exp_num = nxt(exp_num);
            check("run_adv_valid", o_valid, 1);
            check("run_adv_num", o_number, exp_num);
        end

        // Press in RUN: one advance lands during press latency, the press itself does not advance.
        button = 1'b0;
        tick_count(8, cnt);
        check("pause_lat_pulses", cnt, 1);
        exp_num = nxt(exp_num);
        check("pause_num", o_number, exp_num);
        check("pause_running", o_running, 0);
        check("pause_state", o_dbg_state, 2);
        button = 1'b1;
        tick_count(20, cnt);
        check("paused_pulses", cnt, 0);
        check("paused_num", o_number, exp_num);

        // Second press resumes; first advance 4 cycles after re-entry.
        button = 1'b0;
        tick_count(8, cnt);
        check("resume_lat_pulses", cnt, 0);
        check("resume_running", o_running, 1);
        button = 1'b1;
        repeat (3) begin
            tick();
            check("resume_gap_valid", o_valid, 0);
        end
        tick();
        exp_num = nxt(exp_num);
        check("resume_adv_valid", o_valid, 1);
        check("resume_adv_num", o_number, exp_num);

        // Seed load collides with a run advance: load wins, advance dropped.
        repeat (3) tick();
        i_seed      = 8'h5A;
        i_seed_load = 1'b1;
        tick();
        i_seed_load = 1'b0;
        check("seed_num", o_number, 8'h5A);
        check("seed_valid", o_valid, 1);
        check("seed_lockup", o_lockup, 0);
        repeat (3) begin
            tick();
            check("seed_gap_valid", o_valid, 0);
        end
        tick();
        check("seed_next_valid", o_valid, 1);
        check("seed_next_num", o_number, 8'hB4);

        // Zero seed is replaced by SEED with a lockup pulse.
        i_seed      = 8'h00;
        i_seed_load = 1'b1;
        tick();
        i_seed_load = 1'b0;
        check("zseed_num", o_number, 8'h01);
        check("zseed_valid", o_valid, 1);
        check("zseed_lockup", o_lockup, 1);
        tick();
        check("zseed_lockup_drop", o_lockup, 0);
        check("zseed_valid_drop", o_valid, 0);

        // Back to single-step.
        i_mode = 1'b0;
        tick();
        check("step_back_running", o_running, 0);
        check("step_back_state", o_dbg_state, 0);

        // Reset mid-run and mid-debounce discards everything.
        i_mode = 1'b1;
        repeat (7) tick();
        button = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("mrst_num", o_number, 8'h01);
        check("mrst_valid", o_valid, 0);
        check("mrst_running", o_running, 0);
        check("mrst_state", o_dbg_state, 0);
        button = 1'b1;
        i_mode = 1'b0;
        tick();
        rst_n = 1'b1;
        tick_count(20, cnt);
        check("mrst_after_pulses", cnt, 0);
        check("mrst_after_num", o_number, 8'h01);

        // Full period: 255 advances visit every non-zero value once.
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        distinct = 0;
        exp_num  = 8'h01;
        i_mode   = 1'b1;
        for (int i = 0; i < 255; i++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!o_valid && waited < 8);
            if (!o_valid) begin
                check("period_timeout", 1, 0);
                break;
            end
            exp_num = nxt(exp_num);
            if (o_number != exp_num) check("period_step", o_number, exp_num);
            if (o_number != 8'h00 && !seen[o_number]) begin
                seen[o_number] = 1'b1;
                distinct++;
            end
        end
        i_mode = 1'b0;
        prev = o_number;
        check("period_distinct", distinct, 255);
        check("period_return", prev, 8'h01);
        tick();
        check("period_end_running", o_running, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prng_lfsr_ctrl.md
PRNG_LFSR_CTRL -- requirements
Module: prng_lfsr_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning LFSR and output width (legal 4..32).
REQ-002 The block SHALL have parameter TAPS, default 8'hB8, meaning the feedback mask (bit k set means state[k] feeds the XOR).
REQ-003 The block SHALL have parameter SEED, default 1, meaning the reset value and the zero-substitute value (must be non-zero).
REQ-004 The block SHALL have parameter DEBOUNCE, default 4, meaning the consecutive stable cycles required to accept a button level change (>=1).
REQ-005 The block SHALL have parameter PRESCALE, default 4, meaning the clock cycles per advance in run mode (>=1).
REQ-006 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port i_rst_n, input, 1 bit: synchronous active-low reset.
REQ-008 The block SHALL have port button, input, 1 bit: asynchronous active-low push button (low = pressed).
REQ-009 The block SHALL have port i_mode, input, 1 bit: 0 = single-step, 1 = free-run.
REQ-010 The block SHALL have port i_seed, input, WIDTH bits: seed value.
REQ-011 The block SHALL have port i_seed_load, input, 1 bit: load i_seed this cycle.
REQ-012 The block SHALL have port o_number, output, WIDTH bits: current LFSR state.
REQ-013 The block SHALL have port o_valid, output, 1 bit: one-cycle pulse, high in the first cycle a new o_number is visible.
REQ-014 The block SHALL have port o_lockup, output, 1 bit: one-cycle pulse when a zero seed was replaced by SEED.
REQ-015 The block SHALL have port o_running, output, 1 bit: high while the FSM is in RUN.

Function
REQ-016 The block SHALL pass button through a 3-flop synchroniser; the debouncer sees only the third flop.
REQ-017 The block SHALL update the debounced level only after the synchronised level differs from it for DEBOUNCE consecutive cycles; any agreeing cycle SHALL clear the counter.
REQ-018 The block SHALL generate press as a one-cycle pulse on a debounced 1->0 transition; release SHALL generate no event.
REQ-019 The block SHALL compute the advance as next = {state[WIDTH-2:0], fb}, where fb = XOR of state bits selected by TAPS.
REQ-020 The block SHALL implement FSM states STEP, RUN and PAUSE.
- STEP: advance on press; i_mode=1 -> RUN.
- RUN: advance when the prescaler reaches PRESCALE-1; press -> PAUSE; i_mode=0 -> STEP.
- PAUSE: no advance; press -> RUN; i_mode=0 -> STEP.
REQ-021 The block SHALL count the prescaler 0..PRESCALE-1 and wrap it to 0; it SHALL be held at 0 outside RUN and cleared on every RUN entry, so the first run advance occurs PRESCALE cycles after entry.
REQ-022 A press that causes a state transition SHALL NOT also advance the LFSR in the same cycle.
REQ-023 The block SHALL give i_seed_load priority over an advance in the same cycle; the advance is dropped, not deferred.
REQ-024 When i_seed_load loads i_seed == 0, the block SHALL load SEED instead and pulse o_lockup in the cycle the value appears.
REQ-025 The block SHALL pulse o_valid for exactly one cycle after every load or advance, and SHALL hold it low otherwise.
REQ-026 The LFSR state SHALL never be 0 for any input sequence.
REQ-027 Latency: with edge 0 as the first i_clk edge that samples button low, the debounced level SHALL fall at edge 2+DEBOUNCE and the state SHALL update at edge 3+DEBOUNCE.
REQ-028 A button held low SHALL produce exactly one press.

Reset
REQ-029 While i_rst_n is low at a clock edge, the block SHALL set state to SEED, o_valid, o_lockup and o_running to 0, the FSM to STEP, all synchroniser flops and the debounced level to 1, and all counters to 0.
REQ-030 Reset asserted mid-operation (including in RUN or mid-debounce) SHALL take effect at the next edge and discard all pending events.

Verification
REQ-031 Release reset with defaults -> o_number=0x01, o_valid=0, o_running=0.
REQ-032 STEP mode, four clean presses -> o_number goes 0x02, 0x04, 0x08, 0x11, one o_valid pulse each, each at edge 3+DEBOUNCE from its press.
REQ-033 Button low for 3 cycles (DEBOUNCE=4) -> no o_valid and o_number unchanged; low held for 100 cycles -> exactly one advance.
REQ-034 i_mode=1 -> o_valid every 4 cycles, first 4 cycles after RUN entry; press -> o_running=0 and no advances; second press -> resumes.
REQ-035 i_seed_load with i_seed=0x5A in the same cycle as a run advance -> o_number=0x5A, one o_valid; i_seed=0 -> o_number=0x01, o_lockup pulse.
REQ-036 255 advances from 0x01 with TAPS=8'hB8 -> all 255 non-zero values appear once, and the state returns to 0x01.
